// File: rtl/shift_register_4_beh.sv
// rtl/shift_register_4_beh.sv - universal shift register: hold, shift right, shift left, parallel load
module shift_register_4_beh #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  output logic [WIDTH-1:0] A_par
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] a_par_q;
  logic [WIDTH-1:0] a_par_d;

  assign mode = mode_e'({s1, s0});

  always_comb begin
    a_par_d = a_par_q;
    case (mode)
      MODE_HOLD:  a_par_d = a_par_q;
      MODE_RIGHT: a_par_d = {MSB_in, a_par_q[WIDTH-1:1]};
      MODE_LEFT:  a_par_d = {a_par_q[WIDTH-2:0], LSB_in};
      MODE_LOAD:  a_par_d = I_par;
      default:    a_par_d = a_par_q;
    endcase
  end

  // Clear is asynchronous and overrides any clock edge.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      a_par_q <= '0;
    end else begin
      a_par_q <= a_par_d;
    end
  end

  assign A_par = a_par_q;

endmodule

// File: tb/tb_shift_register_4_beh.sv
// tb/tb_shift_register_4_beh.sv - directed self-checking bench for shift_register_4_beh
module tb_shift_register_4_beh;

  logic       CLK;
  logic       Clear_b;
  logic       s1;
  logic       s0;
  logic [3:0] I_par;
  logic       MSB_in;
  logic       LSB_in;
  logic [3:0] A_par;

  int total;
  int bad;

  shift_register_4_beh #(.WIDTH(4)) dut (
    .CLK     (CLK),
    .Clear_b (Clear_b),
    .s1      (s1),
    .s0      (s0),
    .I_par   (I_par),
    .MSB_in  (MSB_in),
    .LSB_in  (LSB_in),
    .A_par   (A_par)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Set inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic [1:0] mode, input logic [3:0] ipar,
                      input logic msb, input logic lsb);
    {s1, s0} = mode;
    I_par    = ipar;
    MSB_in   = msb;
    LSB_in   = lsb;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Clear_b = 1'b0;
    s1      = 1'b1;
    s0      = 1'b1;
    I_par   = 4'b1111;
    MSB_in  = 1'b0;
    LSB_in  = 1'b0;

    #2;
    check("reset_state", A_par, 4'b0000);
    step(2'b11, 4'b1111, 1'b1, 1'b1);
    check("reset_hold_load", A_par, 4'b0000);
    #2;
    Clear_b = 1'b1;
    #1;

    // 1: async clear
    step(2'b11, 4'b1010, 1'b0, 1'b0);
    check("t1_load", A_par, 4'b1010);
    #2;
    Clear_b = 1'b0;
    #1;
    check("t1_async_clear", A_par, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 4'b1111, 1'b1, 1'b1);
      check("t1_clear_held", A_par, 4'b0000);
    end
    #2;
    Clear_b = 1'b1;
    #1;

    // 2: shift left walking one
    step(2'b10, 4'b1111, 1'b1, 1'b1);
    check("t2_sl0", A_par, 4'b0001);
    step(2'b10, 4'b1111, 1'b1, 1'b0);
    check("t2_sl1", A_par, 4'b0010);
    step(2'b10, 4'b1111, 1'b1, 1'b0);
    check("t2_sl2", A_par, 4'b0100);
    step(2'b10, 4'b1111, 1'b1, 1'b0);
    check("t2_sl3", A_par, 4'b1000);
    step(2'b10, 4'b1111, 1'b1, 1'b0);
    check("t2_sl4", A_par, 4'b0000);

    // 3: shift right walking one
    step(2'b01, 4'b1111, 1'b1, 1'b1);
    check("t3_sr0", A_par, 4'b1000);
    step(2'b01, 4'b1111, 1'b0, 1'b1);
    check("t3_sr1", A_par, 4'b0100);
    step(2'b01, 4'b1111, 1'b0, 1'b1);
    check("t3_sr2", A_par, 4'b0010);
    step(2'b01, 4'b1111, 1'b0, 1'b1);
    check("t3_sr3", A_par, 4'b0001);
    step(2'b01, 4'b1111, 1'b0, 1'b1);
    check("t3_sr4", A_par, 4'b0000);

    // 4: parallel load then hold with distracting inputs
    step(2'b11, 4'b1011, 1'b0, 1'b0);
    check("t4_load", A_par, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 4'b0100, 1'b1, 1'b1);
      check("t4_hold", A_par, 4'b1011);
    end

    // 5: mode switching
    step(2'b11, 4'b0110, 1'b1, 1'b1);
    check("t5_load", A_par, 4'b0110);
    step(2'b10, 4'b0000, 1'b1, 1'b1);
    check("t5_sl", A_par, 4'b1101);
    step(2'b01, 4'b1111, 1'b0, 1'b0);
    check("t5_sr", A_par, 4'b0110);

    // 6: clear during shifting
    step(2'b11, 4'b0011, 1'b0, 1'b0);
    check("t6_load", A_par, 4'b0011);
    step(2'b10, 4'b0000, 1'b0, 1'b1);
    check("t6_sl", A_par, 4'b0111);
    #2;
    Clear_b = 1'b0;
    #1;
    check("t6_async_clear", A_par, 4'b0000);
    #2;
    Clear_b = 1'b1;
    #1;
    check("t6_released", A_par, 4'b0000);
    step(2'b10, 4'b0000, 1'b0, 1'b1);
    check("t6_sl_a", A_par, 4'b0001);
    step(2'b10, 4'b0000, 1'b0, 1'b1);
    check("t6_sl_b", A_par, 4'b0011);

    // Input change between edges must not affect the register.
    step(2'b00, 4'b0000, 1'b0, 1'b0);
    s1    = 1'b1;
    s0    = 1'b1;
    I_par = 4'b1100;
    #2;
    check("between_edges", A_par, 4'b0011);
    {s1, s0} = 2'b00;
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
